// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the two register-file write ports (wb0/wb1) among NREQ completion
// sources. The wb0/wb1 outputs also feed the scoreboard writeback-clear
// inputs, so a busy bit clears only when its result actually retires.
// Arbitration is round-robin starting at r_rr_ptr. Results for rd==0 are
// accepted and dropped without using a port. A second request that targets
// the same rd as the port0 winner is deferred, so the two ports never write
// the same register in one cycle. Grants are registered: a result accepted
// in cycle N is presented on wb*_we/rd/data in cycle N+1 for one cycle.
module wb_port_arbiter #(
  parameter  int NREQ = 4,
  parameter  int XLEN = 32,
  parameter  int CW   = 16,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*5-1:0] req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              wb0_we,
  output logic [4:0]        wb0_rd,
  output logic [XLEN-1:0]   wb0_data,
  output logic              wb1_we,
  output logic [4:0]        wb1_rd,
  output logic [XLEN-1:0]   wb1_data,
  output logic [PW-1:0]     rr_ptr_o,
  output logic [CW-1:0]     conflict_cnt,
  output logic [CW-1:0]     stall_cnt
);

  // Index of the k-th candidate in scan order, starting at ptr (mod NREQ).
  // k never reaches NREQ, so a single wrap step is enough.
  function automatic logic [PW-1:0] scan_idx(input logic [PW-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Registered state
  logic [PW-1:0]   r_rr_ptr;
  logic            r_wb0_we;
  logic [4:0]      r_wb0_rd;
  logic [XLEN-1:0] r_wb0_data;
  logic            r_wb1_we;
  logic [4:0]      r_wb1_rd;
  logic [XLEN-1:0] r_wb1_data;
  logic [CW-1:0]   r_conflict_cnt;
  logic [CW-1:0]   r_stall_cnt;

  // Arbitration results
  logic [NREQ-1:0] w_ready_raw;
  logic [NREQ-1:0] w_rd_nz;
  logic [PW-1:0]   w_scan_idx;
  logic [4:0]      w_scan_rd;
  logic            w_g0;
  logic            w_g1;
  logic [PW-1:0]   w_g0_idx;
  logic [PW-1:0]   w_g1_idx;
  logic [4:0]      w_g0_rd;
  logic [4:0]      w_g1_rd;
  logic [XLEN-1:0] w_g0_data;
  logic [XLEN-1:0] w_g1_data;
  logic            w_defer;
  logic            w_stall;
  logic [PW-1:0]   w_last_idx;
  logic [PW-1:0]   w_next_ptr;

  // Flag requesters whose destination is a real register (rd != 0).
  always_comb begin
    w_rd_nz = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_rd_nz[i] = |req_rd[5*i +: 5];
    end
  end

  // Round-robin scan: drop rd==0 results, fill port0 then port1, defer a
  // second request whose rd collides with the port0 winner.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the loop can leave one unassigned and infer a latch.
    w_ready_raw = '0;
    w_scan_idx  = '0;
    w_scan_rd   = '0;
    w_g0        = 1'b0;
    w_g1        = 1'b0;
    w_g0_idx    = '0;
    w_g1_idx    = '0;
    w_g0_rd     = '0;
    w_g1_rd     = '0;
    w_defer     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan_idx = scan_idx(r_rr_ptr, k);
      w_scan_rd  = req_rd[5*w_scan_idx +: 5];
      if (req_valid[w_scan_idx]) begin
        if (w_scan_rd == 5'd0) begin
          // Writes to x0 are architecturally void: accept and discard.
          w_ready_raw[w_scan_idx] = 1'b1;
        end else if (!w_g0) begin
          w_g0                    = 1'b1;
          w_g0_idx                = w_scan_idx;
          w_g0_rd                 = w_scan_rd;
          w_ready_raw[w_scan_idx] = 1'b1;
        end else if (!w_g1) begin
          if (w_scan_rd != w_g0_rd) begin
            w_g1                    = 1'b1;
            w_g1_idx                = w_scan_idx;
            w_g1_rd                 = w_scan_rd;
            w_ready_raw[w_scan_idx] = 1'b1;
          end else begin
            w_defer = 1'b1;
          end
        end
      end
    end
  end

  assign w_g0_data = req_data[XLEN*w_g0_idx +: XLEN];
  assign w_g1_data = req_data[XLEN*w_g1_idx +: XLEN];

  // A valid real-register request that was not accepted this cycle.
  assign w_stall = |(req_valid & w_rd_nz & ~w_ready_raw);

  // Next scan starts just past the last real-register grantee.
  assign w_last_idx = w_g1 ? w_g1_idx : w_g0_idx;
  assign w_next_ptr = (w_last_idx == PW'(NREQ - 1)) ? '0 : w_last_idx + 1'b1;

  // Nothing is accepted while reset is held; in-flight results are lost.
  assign req_ready = w_ready_raw & {NREQ{~rst}};

  // Round-robin pointer advances only when a real-register grant happened.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_g0) begin
      r_rr_ptr <= w_next_ptr;
    end
  end

  // Registered writeback stage: strobe we for one cycle, hold rd/data otherwise.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: rd/data are reset along with we so that the register file and
    // scoreboard never see stale values from before reset on the ports.
    if (rst) begin
      r_wb0_we   <= 1'b0;
      r_wb0_rd   <= '0;
      r_wb0_data <= '0;
      r_wb1_we   <= 1'b0;
      r_wb1_rd   <= '0;
      r_wb1_data <= '0;
    end else begin
      r_wb0_we <= w_g0;
      r_wb1_we <= w_g1;
      if (w_g0) begin
        r_wb0_rd   <= w_g0_rd;
        r_wb0_data <= w_g0_data;
      end
      if (w_g1) begin
        r_wb1_rd   <= w_g1_rd;
        r_wb1_data <= w_g1_data;
      end
    end
  end

  // Saturating event counters for performance tracing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conflict_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (w_defer && (r_conflict_cnt != '1)) begin
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign wb0_we       = r_wb0_we;
  assign wb0_rd       = r_wb0_rd;
  assign wb0_data     = r_wb0_data;
  assign wb1_we       = r_wb1_we;
  assign wb1_rd       = r_wb1_rd;
  assign wb1_data     = r_wb1_data;
  assign rr_ptr_o     = r_rr_ptr;
  assign conflict_cnt = r_conflict_cnt;
  assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
// Table-driven bench for wb_port_arbiter (NREQ=4, XLEN=32, CW=4). Each vector
// carries the request pattern plus the expected ready mask, port winners,
// next rr_ptr and counter events. Expected writeback values are pushed to a
// scoreboard queue when the vector is driven and popped one clock later.
module tb_wb_port_arbiter;

  localparam int NREQ = 4;
  localparam int XLEN = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [3:0]  valid;
    logic [19:0] rd;        // {rd3, rd2, rd1, rd0}
    logic [3:0]  exp_ready;
    logic        p0_v;
    int          p0_i;
    logic        p1_v;
    int          p1_i;
    logic [1:0]  exp_ptr;   // rr_ptr after the clock edge
    logic        exp_conf;
    logic        exp_stall;
  } vec_t;

  typedef struct {
    logic        we0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        we1;
    logic [4:0]  rd1;
    logic [31:0] d1;
  } wb_exp_t;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [19:0]  req_rd;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         wb0_we;
  logic [4:0]   wb0_rd;
  logic [31:0]  wb0_data;
  logic         wb1_we;
  logic [4:0]   wb1_rd;
  logic [31:0]  wb1_data;
  logic [1:0]   rr_ptr_o;
  logic [3:0]   conflict_cnt;
  logic [3:0]   stall_cnt;

  wb_port_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wb0_we       (wb0_we),
    .wb0_rd       (wb0_rd),
    .wb0_data     (wb0_data),
    .wb1_we       (wb1_we),
    .wb1_rd       (wb1_rd),
    .wb1_data     (wb1_data),
    .rr_ptr_o     (rr_ptr_o),
    .conflict_cnt (conflict_cnt),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: held port values and saturating counters.
  logic [4:0]  m_rd0, m_rd1;
  logic [31:0] m_d0, m_d1;
  int          m_conf, m_stall;
  wb_exp_t     sb_q[$];
  logic [3:0]  last_ready;

  vec_t tbl [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic [3:0] valid, input logic [19:0] rd,
                              input logic [3:0] rdy, input logic p0v, input int p0i,
                              input logic p1v, input int p1i, input logic [1:0] ptr,
                              input logic conf, input logic stall);
    vec_t v;
    v.valid = valid; v.rd = rd; v.exp_ready = rdy;
    v.p0_v = p0v; v.p0_i = p0i; v.p1_v = p1v; v.p1_i = p1i;
    v.exp_ptr = ptr; v.exp_conf = conf; v.exp_stall = stall;
    return v;
  endfunction

  function automatic logic [127:0] mk_data(input int vn);
    logic [127:0] d;
    for (int i = 0; i < NREQ; i++) d[32*i +: 32] = 32'h1000_0000 + 32'(vn * 256 + i);
    return d;
  endfunction

  task automatic model_reset();
    m_rd0 = '0; m_rd1 = '0; m_d0 = '0; m_d1 = '0;
    m_conf = 0; m_stall = 0;
    sb_q.delete();
  endtask

  // Called at posedge+1; leaves at posedge+1 with rst released.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one vector, check ready combinationally, push the expected port
  // contents, then compare registered outputs one clock later.
  task automatic step(input vec_t v, input logic [127:0] data, input string tag);
    wb_exp_t e;
    wb_exp_t g;
    req_valid = v.valid;
    req_rd    = v.rd;
    req_data  = data;
    #1;
    last_ready = req_ready;
    check({tag, " ready"}, 64'(req_ready), 64'(v.exp_ready));
    if (v.p0_v) begin
      m_rd0 = v.rd[5*v.p0_i +: 5];
      m_d0  = data[32*v.p0_i +: 32];
    end
    if (v.p1_v) begin
      m_rd1 = v.rd[5*v.p1_i +: 5];
      m_d1  = data[32*v.p1_i +: 32];
    end
    e.we0 = v.p0_v; e.rd0 = m_rd0; e.d0 = m_d0;
    e.we1 = v.p1_v; e.rd1 = m_rd1; e.d1 = m_d1;
    sb_q.push_back(e);
    if (v.exp_conf && m_conf < CMAX) m_conf++;
    if (v.exp_stall && m_stall < CMAX) m_stall++;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s scoreboard: queue empty, expected an entry", tag);
    end else begin
      g = sb_q.pop_front();
      check({tag, " wb0_we"},   64'(wb0_we),   64'(g.we0));
      check({tag, " wb0_rd"},   64'(wb0_rd),   64'(g.rd0));
      check({tag, " wb0_data"}, 64'(wb0_data), 64'(g.d0));
      check({tag, " wb1_we"},   64'(wb1_we),   64'(g.we1));
      check({tag, " wb1_rd"},   64'(wb1_rd),   64'(g.rd1));
      check({tag, " wb1_data"}, 64'(wb1_data), 64'(g.d1));
    end
    check({tag, " rr_ptr"},   64'(rr_ptr_o),     64'(v.exp_ptr));
    check({tag, " conflict"}, 64'(conflict_cnt), 64'(m_conf));
    check({tag, " stall"},    64'(stall_cnt),    64'(m_stall));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int last_g [4];
    int max_gap [4];
    vec_t v;

    // valid, rd{3,2,1,0}, ready, p0v, p0i, p1v, p1i, ptr, conf, stall
    tbl[0]  = mk(4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   4'b0000, 0, 0, 0, 0, 2'd0, 0, 0);
    tbl[1]  = mk(4'b1011, {5'd9, 5'd0, 5'd3, 5'd3},   4'b1001, 1, 0, 1, 3, 2'd0, 1, 1);
    tbl[2]  = mk(4'b0010, {5'd0, 5'd0, 5'd3, 5'd0},   4'b0010, 1, 1, 0, 0, 2'd2, 0, 0);
    tbl[3]  = mk(4'b0010, {5'd0, 5'd0, 5'd0, 5'd0},   4'b0010, 0, 0, 0, 0, 2'd2, 0, 0);
    tbl[4]  = mk(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},   4'b1100, 1, 2, 1, 3, 2'd0, 0, 1);
    tbl[5]  = mk(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},   4'b0011, 1, 0, 1, 1, 2'd2, 0, 1);
    tbl[6]  = mk(4'b1111, {5'd6, 5'd6, 5'd6, 5'd6},   4'b0100, 1, 2, 0, 0, 2'd3, 1, 1);
    tbl[7]  = mk(4'b1111, {5'd0, 5'd8, 5'd8, 5'd0},   4'b1011, 1, 1, 0, 0, 2'd2, 1, 1);
    tbl[8]  = mk(4'b0001, {5'd0, 5'd0, 5'd0, 5'd10},  4'b0001, 1, 0, 0, 0, 2'd1, 0, 0);
    tbl[9]  = mk(4'b1101, {5'd12, 5'd4, 5'd0, 5'd4},  4'b1100, 1, 2, 1, 3, 2'd0, 0, 1);
    tbl[10] = mk(4'b0110, {5'd0, 5'd1, 5'd1, 5'd0},   4'b0010, 1, 1, 0, 0, 2'd2, 1, 1);
    tbl[11] = mk(4'b0100, {5'd0, 5'd1, 5'd0, 5'd0},   4'b0100, 1, 2, 0, 0, 2'd3, 0, 0);
    tbl[12] = mk(4'b1000, {5'd31, 5'd0, 5'd0, 5'd0},  4'b1000, 1, 3, 0, 0, 2'd0, 0, 0);
    tbl[13] = mk(4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   4'b0000, 0, 0, 0, 0, 2'd0, 0, 0);

    // T1: reset held with every requester valid.
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_rd    = {5'd4, 5'd3, 5'd2, 5'd1};
    req_data  = mk_data(0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("t1 ready", 64'(req_ready), 64'd0);
    check("t1 wb0_we", 64'(wb0_we), 64'd0);
    check("t1 wb1_we", 64'(wb1_we), 64'd0);
    check("t1 rr_ptr", 64'(rr_ptr_o), 64'd0);
    check("t1 conflict", 64'(conflict_cnt), 64'd0);
    check("t1 stall", 64'(stall_cnt), 64'd0);
    rst = 1'b0;

    // T2: two different rds from req0 and req2.
    v = mk(4'b0101, {5'd0, 5'd7, 5'd0, 5'd5}, 4'b0101, 1, 0, 1, 2, 2'd3, 0, 0);
    step(v, {32'h0, 32'h22, 32'h0, 32'h11}, "t2");

    // Table sequence from a fresh reset.
    do_reset();
    for (int n = 0; n < 14; n++) step(tbl[n], mk_data(n + 1), $sformatf("v%0d", n));

    // T4: all requesters continuously valid with distinct rds.
    do_reset();
    for (int i = 0; i < 4; i++) begin last_g[i] = -1; max_gap[i] = 0; end
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 0) v = mk(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0011, 1, 0, 1, 1, 2'd2, 0, 1);
      else            v = mk(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1100, 1, 2, 1, 3, 2'd0, 0, 1);
      step(v, mk_data(100 + c), $sformatf("t4c%0d", c));
      for (int i = 0; i < 4; i++) begin
        if (last_ready[i]) begin
          if (c - last_g[i] > max_gap[i]) max_gap[i] = c - last_g[i];
          last_g[i] = c;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (7 - last_g[i] > max_gap[i]) max_gap[i] = 7 - last_g[i];
      check($sformatf("t4 fair%0d gap<=2", i), 64'(max_gap[i] <= 2), 64'd1);
    end

    // T6: same-rd deferral held for 20 cycles saturates conflict_cnt.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if (c % 2 == 0) v = mk(4'b0011, {5'd0, 5'd0, 5'd5, 5'd5}, 4'b0001, 1, 0, 0, 0, 2'd1, 1, 1);
      else            v = mk(4'b0011, {5'd0, 5'd0, 5'd5, 5'd5}, 4'b0010, 1, 1, 0, 0, 2'd2, 1, 1);
      step(v, mk_data(200 + c), $sformatf("t6c%0d", c));
    end
    check("t6 conflict sat", 64'(conflict_cnt), 64'(CMAX));
    check("t6 stall sat", 64'(stall_cnt), 64'(CMAX));

    // Reset mid-grant: outputs clear without waiting for a clock edge.
    check("t6 pre-rst wb0_we", 64'(wb0_we), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6 rst wb0_we", 64'(wb0_we), 64'd0);
    check("t6 rst wb0_rd", 64'(wb0_rd), 64'd0);
    check("t6 rst ready", 64'(req_ready), 64'd0);
    check("t6 rst conflict", 64'(conflict_cnt), 64'd0);
    check("t6 rst stall", 64'(stall_cnt), 64'd0);
    check("t6 rst rr_ptr", 64'(rr_ptr_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
